// File: rtl/stack_cmp_unit.sv
// Operand-stack compare unit: pushes constants, pops operands for i32/i64 eqz/eq/ne/lt_s/lt_u, pushes 0/1.
// Define STACK_CMP_SIGNED_EN to execute 0x48/0x53 (signed lt); otherwise those opcodes trap as invalid.
module stack_cmp_unit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             op_valid,
  input  logic [7:0]       opcode,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             result_empty,
  output logic [2:0]       trap
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_POP_B, S_POP_A, S_EXEC} state_e;
  typedef enum logic [2:0] {
    TRAP_NONE  = 3'd0,
    TRAP_UNDER = 3'd1,
    TRAP_OVER  = 3'd2,
    TRAP_INV   = 3'd3
  } trap_e;
  typedef enum logic [2:0] {OP_EQZ, OP_EQ, OP_NE, OP_LTS, OP_LTU} kind_e;

  logic [WIDTH-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  trap_e            trap_q, trap_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  kind_e            kind_q, kind_d;
  logic             w64_q, w64_d;

  logic             wr_en;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic [SPW-1:0]   sp_m1, sp_m2;

  logic             op_ok, op_w64;
  kind_e            op_kind;
  logic [63:0]      a_x, b_x;
  logic             res;
  logic [WIDTH-1:0] res_word;

  assign sp_m1   = sp_q - SPW'(1);
  assign sp_m2   = sp_q - SPW'(2);
  assign rd_data = mem[rd_idx];

  always_comb begin
    op_ok   = 1'b1;
    op_w64  = opcode[4];
    op_kind = OP_EQZ;
    case (opcode)
      8'h45, 8'h50: op_kind = OP_EQZ;
      8'h46, 8'h51: op_kind = OP_EQ;
      8'h47, 8'h52: op_kind = OP_NE;
      8'h48, 8'h53: op_kind = OP_LTS;
      8'h49, 8'h54: op_kind = OP_LTU;
      default:      op_ok   = 1'b0;
    endcase
    if (op_w64 && (WIDTH == 32)) op_ok = 1'b0;
`ifndef STACK_CMP_SIGNED_EN
    if (op_kind == OP_LTS) op_ok = 1'b0;
`endif
  end

  // i32 operands are sign-extended to 64 bits: this keeps both signed and
  // unsigned ordering of the low words, so one 64-bit comparator serves both.
  always_comb begin
    a_x = 64'(a_q);
    b_x = 64'(b_q);
    if (!w64_q) begin
      a_x = {{32{a_q[31]}}, a_q[31:0]};
      b_x = {{32{b_q[31]}}, b_q[31:0]};
    end
    res = 1'b0;
    case (kind_q)
      OP_EQZ:  res = (a_x == '0);
      OP_EQ:   res = (a_x == b_x);
      OP_NE:   res = (a_x != b_x);
      OP_LTU:  res = (a_x < b_x);
`ifdef STACK_CMP_SIGNED_EN
      OP_LTS:  res = ($signed(a_x) < $signed(b_x));
`endif
      default: res = 1'b0;
    endcase
  end

  assign res_word = {{(WIDTH-1){1'b0}}, res};

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    sp_d    = sp_q;
    top_d   = top_q;
    a_d     = a_q;
    b_d     = b_q;
    kind_d  = kind_q;
    w64_d   = w64_q;
    wr_en   = 1'b0;
    wr_idx  = sp_q[AW-1:0];
    wr_data = push_data;
    rd_idx  = sp_m1[AW-1:0];
    case (state_q)
      S_IDLE: begin
        if (trap_q == TRAP_NONE) begin
          if (push_valid) begin
            if (sp_q == SPW'(DEPTH)) begin
              trap_d = TRAP_OVER;
            end else begin
              wr_en = 1'b1;
              sp_d  = sp_q + SPW'(1);
              top_d = push_data;
            end
          end else if (op_valid) begin
            kind_d = op_kind;
            w64_d  = op_w64;
            if (!op_ok)                     trap_d  = TRAP_INV;
            else if (op_kind == OP_EQZ) begin
              if (sp_q == '0)               trap_d  = TRAP_UNDER;
              else                          state_d = S_POP_A;
            end else if (sp_q < SPW'(2))    trap_d  = TRAP_UNDER;
            else                            state_d = S_POP_B;
          end
        end
      end
      S_POP_B: begin
        rd_idx  = sp_m1[AW-1:0];
        b_d     = rd_data;
        state_d = S_POP_A;
      end
      S_POP_A: begin
        rd_idx  = (kind_q == OP_EQZ) ? sp_m1[AW-1:0] : sp_m2[AW-1:0];
        a_d     = rd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wr_en   = 1'b1;
        wr_data = res_word;
        top_d   = res_word;
        if (kind_q == OP_EQZ) begin
          wr_idx = sp_m1[AW-1:0];
        end else begin
          wr_idx = sp_m2[AW-1:0];
          sp_d   = sp_m1;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      trap_q  <= TRAP_NONE;
      sp_q    <= '0;
      top_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      kind_q  <= OP_EQZ;
      w64_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      sp_q    <= sp_d;
      top_q   <= top_d;
      a_q     <= a_d;
      b_q     <= b_d;
      kind_q  <= kind_d;
      w64_q   <= w64_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_idx] <= wr_data;
  end

  assign ready        = (state_q == S_IDLE) && (trap_q == TRAP_NONE);
  assign result_empty = (sp_q == '0);
  assign result       = result_empty ? '0 : top_q;
  assign trap         = trap_q;
endmodule

// File: doc/stack_cmp_unit.md
# stack_cmp_unit

Parametrised operand-stack comparison unit for the WebAssembly core. Holds a DEPTH-entry operand stack and executes the i32/i64 test and compare opcodes (eqz, eq, ne, lt_s, lt_u) by popping operands and pushing a 0/1 result. It generalises the single hard-wired eqz path into a width- and depth-configurable, handshaked unit. Traps are reported with the core's 3-bit trap encoding. Sits between the decoder and the core's result/trap outputs.

## Interface
- WIDTH, 64, stack entry width; 32 or 64 only
- DEPTH, 16, stack entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- push_valid  in  1  push request for push_data (const)
- push_data  in  WIDTH  value to push
- op_valid  in  1  opcode request
- opcode  in  8  WebAssembly opcode byte
- ready  out  1  unit accepts push or op this cycle
- result  out  WIDTH  current top of stack; 0 when empty
- result_empty  out  1  stack empty
- trap  out  3  0 none, 1 underflow, 2 overflow, 3 invalid opcode; sticky

## Operation
- Opcodes: 0x45 i32.eqz, 0x46 i32.eq, 0x47 i32.ne, 0x48 i32.lt_s, 0x49 i32.lt_u; 0x50 i64.eqz, 0x51 i64.eq, 0x52 i64.ne, 0x53 i64.lt_s, 0x54 i64.lt_u. Anything else: trap 3.
- i32 ops compare bits [31:0] only; i64 ops full 64 bits. WIDTH=32: every 0x50–0x54 opcode traps 3.
- Binary ops: b = top, a = next; result = a OP b (lt: a < b). Pop 2, push result zero-extended to WIDTH (1 or 0).
- eqz: pop 1, push (operand==0).
- Push when not full: entry stored, sp+1. Push when full: trap 2, stack unchanged.
- Underflow (eqz with sp=0; binary with sp<2): trap 1, stack unchanged.
- Simultaneous push_valid and op_valid in one cycle: push takes priority; op is not accepted (caller holds it).
- Any nonzero trap: ready forced 0 until reset; stack frozen.
- FSM: IDLE → (op accepted, binary) POP_B → POP_A → EXEC → IDLE; (eqz) POP_A → EXEC → IDLE; push completes in IDLE. Storage is single-read-port RAM, one read per state.
- Operand count checked in IDLE at acceptance; traps raised there, no RAM access.

## Timing
- Reset (reset=0 at edge): sp=0, state IDLE, trap=0, result=0, result_empty=1, ready=1 on next cycle.
- ready=1 only in IDLE with trap=0.
- Push: accepted edge N; result/result_empty updated after edge N; ready stays 1.
- eqz: accepted edge N; result valid after edge N+2; ready low for 2 cycles.
- Binary: accepted edge N; result valid after edge N+3; ready low for 3 cycles.
- Traps: trap valid after acceptance edge; no further state change.
- Reset mid-operation aborts the op; reset state as above on the following cycle.
- sp width $clog2(DEPTH)+1; full when sp==DEPTH.

## Configuration
- STACK_CMP_SIGNED_EN defined: 0x48 and 0x53 executed as signed two's-complement less-than on the selected width.
- Undefined: 0x48 and 0x53 treated as invalid, trap 3; signed comparator not synthesised.

## Test plan
- Reset, push 0, op 0x50 → after 2 cycles result=1, result_empty=0, trap=0 (matches legacy eqz behaviour).
- Push 5, push 0x1_0000_0005, op 0x46 → result=1 (low 32 equal); same pair with 0x51 → result=0.
- Push 0xFFFF_FFFF_FFFF_FFFF, push 1, op 0x53 → result=1 with STACK_CMP_SIGNED_EN, trap=3 without; op 0x54 → result=0.
- DEPTH=4: push 5 values → 5th raises trap=2, result= 4th value, ready=0; reset → trap=0, result_empty=1.
- Empty stack, op 0x51 → trap=1; one entry + op 0x51 → trap=1; op 0x99 → trap=3.
- Push and op asserted together → push taken, op stalled; reset asserted during POP_A → IDLE, sp=0 next cycle.
